// File: rtl/seg_frame_shifter.sv
// seg_frame_shifter: composes DIGITS hex digits into active-low 7-segment bytes and
// shifts each frame MSB-first into an external shift-register chain, then latches it.
// Optional macro SEG_BLINK_EN builds the blink counter and per-digit blanking via les.
module seg_frame_shifter #(
  parameter int DIGITS     = 8,
  parameter int CLK_DIV    = 2,
  parameter int BLINK_BITS = 24
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] hexs1,
  input  logic [4*DIGITS-1:0] hexs2,
  input  logic                sw,
  input  logic [DIGITS-1:0]   points,
  input  logic [DIGITS-1:0]   les,
  output logic                seg_clk,
  output logic                seg_dat,
  output logic                seg_lat,
  output logic                frame_done
);
  localparam int NB = 8*DIGITS;
  localparam int BW = $clog2(NB+1);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NB-1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV-1);

  typedef enum logic [1:0] {LOAD, SHIFT, LATCH} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   bit_q;
  logic [DW-1:0]   div_q;
  logic            phase_q;   // 0: seg_clk low half, 1: high half
  logic [NB-1:0]   sh_q;
  logic            dat_q;
  logic [NB-1:0]   frame;
  logic [DIGITS-1:0] blank;
  logic            div_last, bit_last;

  // {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    unique case (h)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; 4'hF: g = 7'h0E;
    endcase
    return g;
  endfunction

`ifdef SEG_BLINK_EN
  logic [BLINK_BITS-1:0] blink_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) blink_q <= '0;
    else     blink_q <= blink_q + 1'b1;
  assign blank = les & {DIGITS{blink_q[BLINK_BITS-1]}};
`else
  logic unused_blink;
  assign unused_blink = ^{les, 1'(BLINK_BITS)};
  assign blank = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] nib;
    assign nib = sw ? hexs2[4*i +: 4] : hexs1[4*i +: 4];
    assign frame[8*i +: 8] = blank[i] ? 8'hFF : {~points[i], glyph(nib)};
  end

  assign div_last = (div_q == DIV_LAST);
  assign bit_last = (bit_q == LAST_BIT);

  always_comb begin
    state_d    = state_q;
    seg_clk    = 1'b0;
    seg_lat    = 1'b0;
    frame_done = 1'b0;
    seg_dat    = dat_q;
    unique case (state_q)
      LOAD:  state_d = SHIFT;
      SHIFT: begin
        seg_clk = phase_q;
        if (div_last && phase_q && bit_last) state_d = LATCH;
      end
      LATCH: begin
        seg_lat    = 1'b1;
        frame_done = div_last;
        if (div_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      bit_q   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      sh_q    <= '1;
      dat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        LOAD: begin
          // first bit goes straight to dat_q so it is valid for the whole first low half
          sh_q    <= {frame[NB-2:0], 1'b1};
          dat_q   <= frame[NB-1];
          bit_q   <= '0;
          div_q   <= '0;
          phase_q <= 1'b0;
        end
        SHIFT: begin
          if (!div_last) div_q <= div_q + 1'b1;
          else begin
            div_q   <= '0;
            phase_q <= ~phase_q;
            if (phase_q && !bit_last) begin
              bit_q <= bit_q + 1'b1;
              dat_q <= sh_q[NB-1];
              sh_q  <= {sh_q[NB-2:0], 1'b1};
            end
          end
        end
        LATCH: div_q <= div_last ? '0 : div_q + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_frame_shifter.sv
// Directed bench for seg_frame_shifter: an 8-digit/CLK_DIV=2 instance and a 1-digit/CLK_DIV=1 instance.
module tb_seg_frame_shifter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] hexs1 = '0, hexs2 = '0;
  logic        sw = 1'b0;
  logic [7:0]  points = '0, les = '0;
  logic        seg_clk, seg_dat, seg_lat, frame_done;

  logic [3:0]  hexs1_b = 4'hA, hexs2_b = 4'h0;
  logic        sw_b = 1'b0;
  logic [0:0]  points_b = 1'b1, les_b = 1'b0;
  logic        seg_clk_b, seg_dat_b, seg_lat_b, frame_done_b;

  always #5 clk = ~clk;

  seg_frame_shifter #(.DIGITS(8), .CLK_DIV(2), .BLINK_BITS(4)) dut (
    .clk(clk), .rst(rst), .hexs1(hexs1), .hexs2(hexs2), .sw(sw), .points(points), .les(les),
    .seg_clk(seg_clk), .seg_dat(seg_dat), .seg_lat(seg_lat), .frame_done(frame_done));

  seg_frame_shifter #(.DIGITS(1), .CLK_DIV(1), .BLINK_BITS(4)) dut_b (
    .clk(clk), .rst(rst), .hexs1(hexs1_b), .hexs2(hexs2_b), .sw(sw_b), .points(points_b), .les(les_b),
    .seg_clk(seg_clk_b), .seg_dat(seg_dat_b), .seg_lat(seg_lat_b), .frame_done(frame_done_b));

  int errors = 0;
  int checks = 0;

  // clk edges since reset release; bit 3 is the expected blink MSB for BLINK_BITS=4
  int unsigned tcyc;
  always @(posedge clk or posedge rst)
    if (rst) tcyc <= 0;
    else     tcyc <= tcyc + 1;

  logic [63:0] cap_frame;
  int          cap_bits, cap_lat, cap_period, cap_viol;
  bit          cap_to;
  logic        cap_first_clk, cap_first_dat, cap_flash;

  // Samples one frame at negedges; sync=1 first skips to the end of the frame in flight.
  task automatic capture(input bit sync, input int chg_at, input logic [31:0] chg_val);
    logic pclk, pdat;
    int n;
    cap_frame = '0; cap_bits = 0; cap_lat = 0; cap_period = 0; cap_viol = 0; cap_to = 1'b0;
    if (sync) begin
      n = 0;
      do begin @(negedge clk); n++; end while (frame_done !== 1'b1 && n < 600);
      if (n >= 600) begin cap_to = 1'b1; return; end
    end
    pclk = 1'b0; pdat = seg_dat; n = 0;
    forever begin
      @(negedge clk); n++;
      if (n == 1) begin cap_first_clk = seg_clk; cap_first_dat = seg_dat; cap_flash = tcyc[3]; end
      if (n == chg_at) hexs1 = chg_val;
      if (pclk === 1'b0 && seg_clk === 1'b1) begin cap_frame = {cap_frame[62:0], seg_dat}; cap_bits++; end
      if (seg_dat !== pdat && seg_clk === 1'b1) cap_viol++;
      if (seg_lat === 1'b1) cap_lat++;
      pclk = seg_clk; pdat = seg_dat;
      if (frame_done === 1'b1) begin cap_period = n; return; end
      if (n >= 600) begin cap_to = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (seg_clk !== 1'b0) begin errors++; $display("FAIL reset_seg_clk: got %b expected 0", seg_clk); end
    checks++; if (seg_dat !== 1'b0) begin errors++; $display("FAIL reset_seg_dat: got %b expected 0", seg_dat); end
    checks++; if (seg_lat !== 1'b0) begin errors++; $display("FAIL reset_seg_lat: got %b expected 0", seg_lat); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    hexs1 = 32'h0123_4567; sw = 1'b0; points = 8'h00; les = 8'h00;
    capture(1'b1, 0, '0);
    checks++; if (cap_to !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", cap_to); end
    checks++; if (cap_frame !== 64'hC0F9A4B0999282F8) begin errors++; $display("FAIL basic_frame: got %h expected %h", cap_frame, 64'hC0F9A4B0999282F8); end
    checks++; if (cap_bits !== 64) begin errors++; $display("FAIL basic_bits: got %0d expected 64", cap_bits); end
    checks++; if (cap_lat !== 2) begin errors++; $display("FAIL basic_lat_len: got %0d expected 2", cap_lat); end
    checks++; if (cap_viol !== 0) begin errors++; $display("FAIL basic_dat_stable: got %0d changes expected 0", cap_viol); end
  endtask

  task automatic test_back_to_back();
    capture(1'b0, 0, '0);
    checks++; if (cap_period !== 259) begin errors++; $display("FAIL b2b_period: got %0d expected 259", cap_period); end
    checks++; if (cap_first_clk !== 1'b0 || cap_lat !== 2) begin errors++; $display("FAIL b2b_load_lat: got clk=%b lat=%0d expected clk=0 lat=2", cap_first_clk, cap_lat); end
    checks++; if (cap_frame !== 64'hC0F9A4B0999282F8) begin errors++; $display("FAIL b2b_frame: got %h expected %h", cap_frame, 64'hC0F9A4B0999282F8); end
  endtask

  task automatic test_sw_points();
    sw = 1'b1; hexs2 = 32'h8888_8888; points = 8'h01;
    capture(1'b1, 0, '0);
    checks++; if (cap_frame !== 64'h8080808080808000) begin errors++; $display("FAIL sw_points_frame: got %h expected %h", cap_frame, 64'h8080808080808000); end
    sw = 1'b0; hexs1 = 32'h89AB_CDEF; points = 8'hA5;
    capture(1'b1, 0, '0);
    checks++; if (cap_frame !== 64'h00900883C621860E) begin errors++; $display("FAIL glyphs_points_frame: got %h expected %h", cap_frame, 64'h00900883C621860E); end
    checks++; if (cap_bits !== 64) begin errors++; $display("FAIL glyphs_bits: got %0d expected 64", cap_bits); end
  endtask

  task automatic test_midframe();
    hexs1 = 32'h0; points = 8'h00;
    capture(1'b1, 60, 32'hFFFF_FFFF);
    checks++; if (cap_frame !== 64'hC0C0C0C0C0C0C0C0) begin errors++; $display("FAIL midframe_current: got %h expected %h", cap_frame, 64'hC0C0C0C0C0C0C0C0); end
    capture(1'b0, 0, '0);
    checks++; if (cap_frame !== 64'h8E8E8E8E8E8E8E8E) begin errors++; $display("FAIL midframe_next: got %h expected %h", cap_frame, 64'h8E8E8E8E8E8E8E8E); end
  endtask

  task automatic test_reset_mid();
    int n, lat;
    hexs1 = 32'h0123_4567; points = 8'h00;
    capture(1'b1, 0, '0);
    // now at the frame_done sample: next negedge is LOAD, then 100 SHIFT cycles
    repeat (101) @(negedge clk);
    checks++; if (seg_clk !== 1'b1 || seg_dat !== 1'b1) begin errors++; $display("FAIL pre_reset_state: got clk=%b dat=%b expected clk=1 dat=1", seg_clk, seg_dat); end
    rst = 1'b1;
    #1;
    checks++; if ({seg_clk, seg_dat, seg_lat, frame_done} !== 4'b0000) begin errors++; $display("FAIL abort_outputs: got %b expected 0000", {seg_clk, seg_dat, seg_lat, frame_done}); end
    lat = 0;
    for (n = 0; n < 3; n++) begin @(negedge clk); if (seg_lat !== 1'b0) lat++; end
    checks++; if (lat !== 0) begin errors++; $display("FAIL abort_no_latch: got %0d latch cycles expected 0", lat); end
    rst = 1'b0;
    capture(1'b0, 0, '0);
    checks++; if (cap_first_clk !== 1'b0 || cap_first_dat !== 1'b1) begin errors++; $display("FAIL restart_first_bit: got clk=%b dat=%b expected clk=0 dat=1", cap_first_clk, cap_first_dat); end
    checks++; if (cap_frame !== 64'hC0F9A4B0999282F8 || cap_period !== 258) begin errors++; $display("FAIL restart_frame: got %h/%0d expected %h/258", cap_frame, cap_period, 64'hC0F9A4B0999282F8); end
  endtask

  task automatic test_blink();
    logic [63:0] exp;
    hexs1 = 32'hFFFF_FFFF; points = 8'h00;
`ifdef SEG_BLINK_EN
    les = 8'h80;
    capture(1'b1, 0, '0);
    for (int f = 0; f < 6; f++) begin
      if (f > 0) capture(1'b0, 0, '0);
      exp = {(cap_flash ? 8'hFF : 8'h8E), 56'h8E8E8E8E8E8E8E};
      checks++; if (cap_frame !== exp) begin errors++; $display("FAIL blink_frame%0d: got %h expected %h", f, cap_frame, exp); end
    end
`else
    les = 8'hFF;
    exp = 64'h8E8E8E8E8E8E8E8E;
    capture(1'b1, 0, '0);
    for (int f = 0; f < 3; f++) begin
      if (f > 0) capture(1'b0, 0, '0);
      checks++; if (cap_frame !== exp) begin errors++; $display("FAIL les_ignored%0d: got %h expected %h", f, cap_frame, exp); end
    end
`endif
    les = 8'h00;
  endtask

  task automatic test_small();
    int n, bad, rises;
    logic pclk;
    logic [7:0] byte_v;
    n = 0;
    do begin @(negedge clk); n++; end while (frame_done_b !== 1'b1 && n < 100);
    checks++; if (n >= 100) begin errors++; $display("FAIL small_timeout: got %0d cycles expected <100", n); end
    n = 0; bad = 0; rises = 0; pclk = 1'b0; byte_v = '0;
    do begin
      @(negedge clk); n++;
      if (n >= 2 && n <= 17 && seg_clk_b !== (n % 2 == 1)) bad++;
      if (pclk === 1'b0 && seg_clk_b === 1'b1) begin byte_v = {byte_v[6:0], seg_dat_b}; rises++; end
      pclk = seg_clk_b;
    end while (frame_done_b !== 1'b1 && n < 100);
    checks++; if (n !== 18) begin errors++; $display("FAIL small_period: got %0d expected 18", n); end
    checks++; if (bad !== 0 || rises !== 8) begin errors++; $display("FAIL small_toggle: got bad=%0d rises=%0d expected 0/8", bad, rises); end
    checks++; if (byte_v !== 8'h08) begin errors++; $display("FAIL small_byte: got %h expected 08", byte_v); end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_sw_points();
    test_midframe();
    test_reset_mid();
    test_blink();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
